recirc_ctrl_fsm: RTL and testbench

Control state machine that sequences the recirculation stage of the 4-lane datapath. It drives the IDL select: IDL=1 routes lane data to the probador, IDL=0 routes it to L1. It also latches and distributes the FIFO almost-full/almost-empty thresholds and detects FIFO errors. It sits beside the recirculation mux and the lane FIFOs, and is their only source of IDL and threshold values.

---
 rtl/recirc_ctrl_fsm.sv | 138 +++++++++++++
 tb/tb_recirc_ctrl_fsm.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/recirc_ctrl_fsm.sv
// Recirculation control FSM: drives the IDL select, latches FIFO thresholds
// and keeps a sticky record of lanes that reported FIFO errors.
module recirc_ctrl_fsm #(
    parameter int unsigned THR_W     = 4,
    parameter int unsigned IDLE_HOLD = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [THR_W-1:0] umbral_alto_in,
    input  logic [THR_W-1:0] umbral_bajo_in,
    input  logic [3:0]       fifo_empty,
    input  logic [3:0]       fifo_error,
    input  logic [3:0]       valid_in,
    output logic             IDL,
    output logic [THR_W-1:0] umbral_alto,
    output logic [THR_W-1:0] umbral_bajo,
    output logic             error_out,
    output logic [3:0]       error_lanes,
    output logic [2:0]       state,
    output logic             active_out
);

    typedef enum logic [2:0] {
        StReset  = 3'd0,
        StInit   = 3'd1,
        StIdle   = 3'd2,
        StActive = 3'd3,
        StError  = 3'd4
    } state_e;

    // IDLE_HOLD is limited to 1..15, so four counter bits always suffice.
    localparam int unsigned CntW = 4;
    localparam logic [CntW-1:0] HoldLast = CntW'(IDLE_HOLD - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [THR_W-1:0] alto_q, alto_d;
    logic [THR_W-1:0] bajo_q, bajo_d;
    logic [3:0]       lanes_q, lanes_d;
    logic             quiet;
    logic             any_error;

    always_comb begin
        quiet     = (fifo_empty == 4'b1111) && (valid_in == 4'b0000);
        any_error = |fifo_error;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        alto_d  = alto_q;
        bajo_d  = bajo_q;
        lanes_d = lanes_q;

        unique case (state_q)
            StReset: begin
                state_d = StInit;
            end

            StInit: begin
                alto_d = umbral_alto_in;
                bajo_d = umbral_bajo_in;
                if (!init && (umbral_bajo_in < umbral_alto_in)) begin
                    state_d = StIdle;
                end
            end

            StIdle: begin
                if (any_error) begin
                    state_d = StError;
                    lanes_d = lanes_q | fifo_error;
                end else if (init) begin
                    state_d = StInit;
                end else if (!quiet) begin
                    state_d = StActive;
                    cnt_d   = '0;
                end
            end

            StActive: begin
                if (any_error) begin
                    state_d = StError;
                    lanes_d = lanes_q | fifo_error;
                    cnt_d   = '0;
                end else if (init) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end else if (quiet) begin
                    if (cnt_q == HoldLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            StError: begin
                // Terminal until reset; keep accumulating late-reporting lanes.
                lanes_d = lanes_q | fifo_error;
            end

            default: begin
                state_d = StReset;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StReset;
            cnt_q   <= '0;
            alto_q  <= '0;
            bajo_q  <= '0;
            lanes_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alto_q  <= alto_d;
            bajo_q  <= bajo_d;
            lanes_q <= lanes_d;
        end
    end

    always_comb begin
        state       = state_q;
        IDL         = (state_q == StIdle);
        active_out  = (state_q == StActive);
        error_out   = (state_q == StError);
        umbral_alto = alto_q;
        umbral_bajo = bajo_q;
        error_lanes = lanes_q;
    end

endmodule

// File: tb/tb_recirc_ctrl_fsm.sv
// Scoreboard bench for recirc_ctrl_fsm: directed steps push expected
// post-edge outputs, a negedge monitor pops and compares them.
module tb_recirc_ctrl_fsm;

    localparam int unsigned THR_W = 4;

    logic             clk;
    logic             reset;
    logic             init;
    logic [THR_W-1:0] umbral_alto_in;
    logic [THR_W-1:0] umbral_bajo_in;
    logic [3:0]       fifo_empty;
    logic [3:0]       fifo_error;
    logic [3:0]       valid_in;
    logic             IDL;
    logic [THR_W-1:0] umbral_alto;
    logic [THR_W-1:0] umbral_bajo;
    logic             error_out;
    logic [3:0]       error_lanes;
    logic [2:0]       state;
    logic             active_out;

    recirc_ctrl_fsm #(
        .THR_W    (THR_W),
        .IDLE_HOLD(2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .umbral_alto_in(umbral_alto_in),
        .umbral_bajo_in(umbral_bajo_in),
        .fifo_empty    (fifo_empty),
        .fifo_error    (fifo_error),
        .valid_in      (valid_in),
        .IDL           (IDL),
        .umbral_alto   (umbral_alto),
        .umbral_bajo   (umbral_bajo),
        .error_out     (error_out),
        .error_lanes   (error_lanes),
        .state         (state),
        .active_out    (active_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [2:0]       st;
        logic [THR_W-1:0] alto;
        logic [THR_W-1:0] bajo;
        logic [3:0]       lanes;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Monitor: one expectation is pushed 1 time unit after each edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic exp_idl, exp_act, exp_err;
            e       = sb.pop_front();
            exp_idl = (e.st == 3'd2);
            exp_act = (e.st == 3'd3);
            exp_err = (e.st == 3'd4);
            n_cmp++;
            if (state !== e.st || IDL !== exp_idl || active_out !== exp_act ||
                error_out !== exp_err || umbral_alto !== e.alto ||
                umbral_bajo !== e.bajo || error_lanes !== e.lanes) begin
                n_fail++;
                $display("FAIL %s: got st=%0d IDL=%b act=%b err=%b alto=%0d bajo=%0d lanes=%b; want st=%0d IDL=%b act=%b err=%b alto=%0d bajo=%0d lanes=%b",
                         e.name, state, IDL, active_out, error_out, umbral_alto,
                         umbral_bajo, error_lanes, e.st, exp_idl, exp_act, exp_err,
                         e.alto, e.bajo, e.lanes);
            end
        end
    end

    task automatic step(input string name, input logic rst, input logic in_init,
                        input logic [3:0] a_in, input logic [3:0] b_in,
                        input logic [3:0] empty, input logic [3:0] err,
                        input logic [3:0] valid, input logic [2:0] e_st,
                        input logic [3:0] e_alto, input logic [3:0] e_bajo,
                        input logic [3:0] e_lanes);
        exp_t e;
        reset          = rst;
        init           = in_init;
        umbral_alto_in = a_in;
        umbral_bajo_in = b_in;
        fifo_empty     = empty;
        fifo_error     = err;
        valid_in       = valid;
        @(posedge clk);
        #1;
        e.name  = name;
        e.st    = e_st;
        e.alto  = e_alto;
        e.bajo  = e_bajo;
        e.lanes = e_lanes;
        sb.push_back(e);
    endtask

    localparam logic [3:0] Q = 4'b1111;  // all FIFOs empty
    localparam logic [3:0] Z = 4'b0000;

    initial begin
        // 1: reset and release
        step("rst0",        1, 1, 6, 2, Q, Z, Z, 0, 0, 0, 4'b0000);
        step("rst1",        1, 1, 6, 2, Q, Z, Z, 0, 0, 0, 4'b0000);
        step("rel_init",    0, 1, 6, 2, Q, Z, Z, 1, 0, 0, 4'b0000);
        // 2: load thresholds and go idle
        step("init_hold",   0, 1, 6, 2, Q, Z, Z, 1, 6, 2, 4'b0000);
        step("init_err_ig", 0, 1, 6, 2, Q, 4'b1111, Z, 1, 6, 2, 4'b0000);
        step("to_idle",     0, 0, 6, 2, Q, Z, Z, 2, 6, 2, 4'b0000);
        step("idle_quiet",  0, 0, 9, 9, Q, Z, Z, 2, 6, 2, 4'b0000);
        // 3: equal thresholds block exit from INIT
        step("idle_to_init",0, 1, 3, 3, Q, Z, Z, 1, 6, 2, 4'b0000);
        step("eq_stay0",    0, 0, 3, 3, Q, Z, Z, 1, 3, 3, 4'b0000);
        step("eq_stay1",    0, 0, 3, 3, Q, Z, Z, 1, 3, 3, 4'b0000);
        step("bajo_lower",  0, 0, 3, 1, Q, Z, Z, 2, 3, 1, 4'b0000);
        // 4: quiet hold count
        step("to_active",   0, 0, 0, 0, 4'b1101, Z, Z, 3, 3, 1, 4'b0000);
        step("quiet1",      0, 0, 0, 0, Q, Z, Z, 3, 3, 1, 4'b0000);
        step("quiet2_idle", 0, 0, 0, 0, Q, Z, Z, 2, 3, 1, 4'b0000);
        step("to_active2",  0, 0, 0, 0, 4'b1101, Z, Z, 3, 3, 1, 4'b0000);
        step("q1",          0, 0, 0, 0, Q, Z, Z, 3, 3, 1, 4'b0000);
        step("valid_break", 0, 0, 0, 0, Q, Z, 4'b0010, 3, 3, 1, 4'b0000);
        step("q1_again",    0, 0, 0, 0, Q, Z, Z, 3, 3, 1, 4'b0000);
        step("q2_idle",     0, 0, 0, 0, Q, Z, Z, 2, 3, 1, 4'b0000);
        // 5: error in ACTIVE is sticky and accumulates
        step("to_active3",  0, 0, 0, 0, 4'b1101, Z, Z, 3, 3, 1, 4'b0000);
        step("act_err",     0, 0, 0, 0, Q, 4'b0100, Z, 4, 3, 1, 4'b0100);
        step("err_accum",   0, 1, 0, 0, Q, 4'b0001, Z, 4, 3, 1, 4'b0101);
        step("err_hold",    0, 0, 0, 0, Q, Z, Z, 4, 3, 1, 4'b0101);
        step("err_reset",   1, 0, 5, 1, Q, Z, Z, 0, 0, 0, 4'b0000);
        // 6: error wins over init in IDLE; reset mid-count
        step("rel2",        0, 0, 5, 1, Q, Z, Z, 1, 0, 0, 4'b0000);
        step("idle2",       0, 0, 5, 1, Q, Z, Z, 2, 5, 1, 4'b0000);
        step("err_over_init",0, 1, 5, 1, Q, 4'b1000, Z, 4, 5, 1, 4'b1000);
        step("rst3",        1, 0, 5, 1, Q, Z, Z, 0, 0, 0, 4'b0000);
        step("rel3",        0, 0, 5, 1, Q, Z, Z, 1, 0, 0, 4'b0000);
        step("idle3",       0, 0, 5, 1, Q, Z, Z, 2, 5, 1, 4'b0000);
        step("to_active4",  0, 0, 5, 1, 4'b1101, Z, Z, 3, 5, 1, 4'b0000);
        step("mid_count",   0, 0, 5, 1, Q, Z, Z, 3, 5, 1, 4'b0000);
        step("rst_mid",     1, 0, 5, 1, Q, Z, Z, 0, 0, 0, 4'b0000);
        step("rel4",        0, 0, 5, 1, Q, Z, Z, 1, 0, 0, 4'b0000);
        // Counter was cleared by reset: a fresh hold needs two quiet edges.
        step("idle4",       0, 0, 5, 1, Q, Z, Z, 2, 5, 1, 4'b0000);
        step("to_active5",  0, 0, 5, 1, 4'b1101, Z, Z, 3, 5, 1, 4'b0000);
        step("fresh_q1",    0, 0, 5, 1, Q, Z, Z, 3, 5, 1, 4'b0000);
        step("act_init",    0, 1, 7, 2, Q, Z, Z, 1, 5, 1, 4'b0000);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
